operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- RV32I integer register file plus a one-entry operand pipeline register.
- Sits directly upstream of the ALU. Decode supplies source register addresses and control fields; this stage reads rs1/rs2 and presents registered operands, immediateI, funct3, funct7 and aluMode to the ALU under valid/ready handshake.
- Writeback drives its single write port.

Parameters:
- DATA_WIDTH, 32, width of registers and operands.
- REG_COUNT, 32, architectural registers; x0 hardwired to zero.
- ADDR_WIDTH, 5, register address width; must equal clog2(REG_COUNT).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode offers an instruction.
- in_ready  output  1  stage accepts this cycle.
- rs1_addr_in  input  ADDR_WIDTH  source 1 index.
- rs2_addr_in  input  ADDR_WIDTH  source 2 index.
- rd_addr_in  input  ADDR_WIDTH  destination index, passed through.
- immediateI_in  input  32  I-type immediate, passed through.
- funct3_in  input  3  passed through.
- funct7_in  input  7  passed through.
- aluMode_in  input  ALUMode_t  REGISTER/OP_IMM, passed through.
- out_valid  output  1  registered operands valid.
- out_ready  input  1  ALU consumes this cycle.
- rs1  output  32  registered rs1 value.
- rs2  output  32  registered rs2 value.
- immediateI, funct3, funct7, aluMode, rd_addr  output  as inputs  registered copies.
- wr_en  input  1  writeback write enable.
- wr_addr  input  ADDR_WIDTH  writeback index.
- wr_data  input  32  writeback value.

Behaviour:
- Reset (reset low, asynchronous):
  - x1..x31 cleared to 0.
  - out_valid=0; rs1, rs2, immediateI, funct3, funct7, rd_addr = 0; aluMode=REGISTER.
  - Reset mid-transfer discards the held instruction.
- Register file:
  - Writes are synchronous on the rising edge when wr_en=1 and wr_addr!=0.
  - Writes to x0 are ignored.
  - Reads are combinational from the array; index 0 always returns 0.
- Two-state FSM:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !out_valid || out_ready (combinational, no skid).
- Transitions:
  - EMPTY -> FULL when in_valid.
  - FULL -> FULL when out_ready && in_valid (back-to-back; new operands loaded).
  - FULL -> EMPTY when out_ready && !in_valid.
  - FULL and !out_ready: hold.
- Accept (in_valid && in_ready):
  - Operands and control fields captured at the edge.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 instruction per cycle when out_ready stays high.
- Hold: while FULL && !out_ready, immediateI, funct3, funct7, aluMode and rd_addr are stable.
- Stall refresh: while FULL && !out_ready, a write (wr_en, wr_addr!=0) whose wr_addr equals the held rs1 index updates rs1 to wr_data at that edge. Same rule for rs2. Both update if both indices match. The held rs1/rs2 indices are stored internally.
- Same-edge write and capture to the same index: behaviour is defined by the Optional Feature.
- Addresses out of range are impossible when ADDR_WIDTH=5. For smaller REG_COUNT, out-of-range reads return 0 and out-of-range writes are dropped.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined: on accept, if wr_en && wr_addr!=0 && wr_addr==rs1_addr_in, captured rs1 = wr_data. Same for rs2.
- Undefined: the captured value is the pre-write array contents. Upstream hazard logic must stall until the write has retired.
- Stall refresh is present in both builds.

Test Plan:
- Reset: assert reset low mid-cycle while FULL → out_valid=0 immediately. All regs read 0; in_ready=1 after release.
- Write x5=0xDEADBEEF, next cycle accept rs1=5, rs2=0, in_valid=1 → next cycle out_valid=1, rs1=0xDEADBEEF, rs2=0. A write to x0 of 0x1234 still reads 0.
- Back-to-back: out_ready=1, three accepts (x1..x3 preloaded 1,2,3) → out_valid high three consecutive cycles with rs1=1,2,3. in_ready is never low.
- Backpressure: FULL with out_ready=0, in_valid=1 → in_ready=0 and outputs held. A write of x7=0x55 while held rs2=x7 → rs2 becomes 0x55 at that edge. Release out_ready → instruction consumed.
- Same-edge hazard: accept rs1=x9 while wr_en writes x9=0xA5A5A5A5, x9 previously 0x11 → rs1=0xA5A5A5A5 with OPERAND_FETCH_BYPASS_EN defined, 0x11 without.
- Drain: FULL, out_ready=1, in_valid=0 → out_valid=0 next cycle; control outputs retain their last values.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// Shared types and handshake bundle for operand_fetch_stage.
//   operand_fetch_stage_pkg : ALUMode_t (REGISTER / OP_IMM).
//   operand_fetch_stage_if  : decode-side request (in_*), ALU-side result
//                             (out_*, registered operands and control) and
//                             the writeback write port (wr_*).
//   modport master : drives requests, writes and out_ready (decode/ALU/writeback side).
//   modport slave  : the operand fetch stage itself.
package operand_fetch_stage_pkg;
    typedef enum logic {
        REGISTER = 1'b0,
        OP_IMM   = 1'b1
    } ALUMode_t;
endpackage

interface operand_fetch_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    // Decode side
    logic                               in_valid;
    logic                               in_ready;
    logic [ADDR_WIDTH-1:0]              rs1_addr_in;
    logic [ADDR_WIDTH-1:0]              rs2_addr_in;
    logic [ADDR_WIDTH-1:0]              rd_addr_in;
    logic [31:0]                        immediateI_in;
    logic [2:0]                         funct3_in;
    logic [6:0]                         funct7_in;
    operand_fetch_stage_pkg::ALUMode_t  aluMode_in;

    // ALU side
    logic                               out_valid;
    logic                               out_ready;
    logic [DATA_WIDTH-1:0]              rs1;
    logic [DATA_WIDTH-1:0]              rs2;
    logic [31:0]                        immediateI;
    logic [2:0]                         funct3;
    logic [6:0]                         funct7;
    operand_fetch_stage_pkg::ALUMode_t  aluMode;
    logic [ADDR_WIDTH-1:0]              rd_addr;

    // Writeback port
    logic                               wr_en;
    logic [ADDR_WIDTH-1:0]              wr_addr;
    logic [DATA_WIDTH-1:0]              wr_data;

    modport master (
        output in_valid, rs1_addr_in, rs2_addr_in, rd_addr_in, immediateI_in,
               funct3_in, funct7_in, aluMode_in, out_ready, wr_en, wr_addr, wr_data,
        input  in_ready, out_valid, rs1, rs2, immediateI, funct3, funct7, aluMode, rd_addr
    );

    modport slave (
        input  in_valid, rs1_addr_in, rs2_addr_in, rd_addr_in, immediateI_in,
               funct3_in, funct7_in, aluMode_in, out_ready, wr_en, wr_addr, wr_data,
        output in_ready, out_valid, rs1, rs2, immediateI, funct3, funct7, aluMode, rd_addr
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: RV32I register file (x0 hardwired to zero, one
// synchronous write port) feeding a one-entry operand register in front of
// the ALU under a valid/ready handshake.
//   clock : rising-edge clock.
//   reset : asynchronous active-low reset.
//   bus   : operand_fetch_stage_if.slave (decode request, ALU result, writeback).
// Build option: OPERAND_FETCH_BYPASS_EN forwards a same-edge writeback into
// the operands being captured; without it the pre-write value is captured.
module operand_fetch_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    operand_fetch_stage_if.slave   bus
);
    import operand_fetch_stage_pkg::*;

    if (ADDR_WIDTH != $clog2(REG_COUNT)) begin : g_bad_cfg
        $error("operand_fetch_stage: ADDR_WIDTH must equal clog2(REG_COUNT)");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  regs_q [REG_COUNT];

    logic [DATA_WIDTH-1:0]  rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0]  rs2_q, rs2_d;
    logic [ADDR_WIDTH-1:0]  rs1_idx_q, rs1_idx_d;
    logic [ADDR_WIDTH-1:0]  rs2_idx_q, rs2_idx_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [31:0]            imm_q, imm_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [6:0]             funct7_q, funct7_d;
    ALUMode_t               mode_q, mode_d;

    logic                   in_ready_c;
    logic                   accept_c;
    logic                   wr_ok_c;
    logic [DATA_WIDTH-1:0]  rs1_rd_c;
    logic [DATA_WIDTH-1:0]  rs2_rd_c;

    // Index addresses an implemented register (only matters when REG_COUNT < 2**ADDR_WIDTH).
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < REG_COUNT;
    endfunction

    // Handshake: no skid, so the stage takes a new entry only if empty or draining.
    assign in_ready_c = (state_q == EMPTY) || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign wr_ok_c    = bus.wr_en && (bus.wr_addr != '0) && in_range(bus.wr_addr);

    // Combinational array reads; x0 and unimplemented indices read zero.
    always_comb begin
        rs1_rd_c = '0;
        rs2_rd_c = '0;
        if ((bus.rs1_addr_in != '0) && in_range(bus.rs1_addr_in)) rs1_rd_c = regs_q[bus.rs1_addr_in];
        if ((bus.rs2_addr_in != '0) && in_range(bus.rs2_addr_in)) rs2_rd_c = regs_q[bus.rs2_addr_in];
    end

    // Next state for the FSM and the operand register.
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rs1_idx_d = rs1_idx_q;
        rs2_idx_d = rs2_idx_q;
        rd_addr_d = rd_addr_q;
        imm_d     = imm_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        mode_d    = mode_q;

        case (state_q)
            EMPTY: if (bus.in_valid) state_d = FULL;
            FULL:  if (bus.out_ready) state_d = bus.in_valid ? FULL : EMPTY;
        endcase

        if (accept_c) begin
            rs1_d     = rs1_rd_c;
            rs2_d     = rs2_rd_c;
`ifdef OPERAND_FETCH_BYPASS_EN
            if (wr_ok_c && (bus.wr_addr == bus.rs1_addr_in)) rs1_d = bus.wr_data;
            if (wr_ok_c && (bus.wr_addr == bus.rs2_addr_in)) rs2_d = bus.wr_data;
`endif
            rs1_idx_d = bus.rs1_addr_in;
            rs2_idx_d = bus.rs2_addr_in;
            rd_addr_d = bus.rd_addr_in;
            imm_d     = bus.immediateI_in;
            funct3_d  = bus.funct3_in;
            funct7_d  = bus.funct7_in;
            mode_d    = bus.aluMode_in;
        end else if ((state_q == FULL) && !bus.out_ready) begin
            // Stalled entry tracks writebacks to its sources so it is never stale when consumed.
            if (wr_ok_c && (bus.wr_addr == rs1_idx_q)) rs1_d = bus.wr_data;
            if (wr_ok_c && (bus.wr_addr == rs2_idx_q)) rs2_d = bus.wr_data;
        end
    end

    // Register file; entry 0 is never written and stays zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
        end else if (wr_ok_c) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // FSM state and operand register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
            rd_addr_q <= '0;
            imm_q     <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            mode_q    <= REGISTER;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rs1_idx_q <= rs1_idx_d;
            rs2_idx_q <= rs2_idx_d;
            rd_addr_q <= rd_addr_d;
            imm_q     <= imm_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            mode_q    <= mode_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (state_q == FULL);
    assign bus.rs1        = rs1_q;
    assign bus.rs2        = rs2_q;
    assign bus.immediateI = imm_q;
    assign bus.funct3     = funct3_q;
    assign bus.funct7     = funct7_q;
    assign bus.aluMode    = mode_q;
    assign bus.rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: a reference register file and
// a scoreboard queue of expected operand-register contents, pushed on accept
// and popped when the ALU side consumes.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned RC = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    operand_fetch_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    operand_fetch_stage #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        ALUMode_t    mode;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [31:0] mdl [RC];
    bit          exp_full;
    int          checks = 0;
    int          errors = 0;

    task automatic model_reset();
        sb.delete();
        exp_full = 1'b0;
        last = '{rs1: '0, rs2: '0, imm: '0, f3: '0, f7: '0, mode: REGISTER, rd: '0, a1: '0, a2: '0};
        for (int i = 0; i < int'(RC); i++) mdl[i] = '0;
    endtask

    task automatic set_in(input bit v, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [2:0] f3, input logic [6:0] f7, input ALUMode_t m);
        bus.in_valid      = v;
        bus.rs1_addr_in   = a1;
        bus.rs2_addr_in   = a2;
        bus.rd_addr_in    = rd;
        bus.immediateI_in = imm;
        bus.funct3_in     = f3;
        bus.funct7_in     = f7;
        bus.aluMode_in    = m;
    endtask

    task automatic set_wr(input bit en, input logic [4:0] a, input logic [31:0] d);
        bus.wr_en   = en;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    // Advance model and DUT by one clock edge; leaves time at posedge + 1.
    task automatic tick();
        exp_t e;
        bit   acc;
        bit   wr;
        acc = bus.in_valid && (!exp_full || bus.out_ready);
        wr  = bus.wr_en && (bus.wr_addr != 5'd0);
        if (exp_full && bus.out_ready) begin
            last = sb.pop_front();
        end else if (exp_full && wr) begin
            if (sb[0].a1 == bus.wr_addr) sb[0].rs1 = bus.wr_data;
            if (sb[0].a2 == bus.wr_addr) sb[0].rs2 = bus.wr_data;
        end
        if (acc) begin
            e.a1   = bus.rs1_addr_in;
            e.a2   = bus.rs2_addr_in;
            e.rs1  = (e.a1 == 5'd0) ? 32'd0 : mdl[e.a1];
            e.rs2  = (e.a2 == 5'd0) ? 32'd0 : mdl[e.a2];
`ifdef OPERAND_FETCH_BYPASS_EN
            if (wr && bus.wr_addr == e.a1) e.rs1 = bus.wr_data;
            if (wr && bus.wr_addr == e.a2) e.rs2 = bus.wr_data;
`endif
            e.imm  = bus.immediateI_in;
            e.f3   = bus.funct3_in;
            e.f7   = bus.funct7_in;
            e.mode = bus.aluMode_in;
            e.rd   = bus.rd_addr_in;
            sb.push_back(e);
        end
        if (wr) mdl[bus.wr_addr] = bus.wr_data;
        exp_full = acc || (exp_full && !bus.out_ready);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t h;
        model_reset();
        #1;
        h = last;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.rs1 !== h.rs1 || bus.rs2 !== h.rs2) begin errors++; $display("FAIL reset_operands: got %h/%h want %h/%h", bus.rs1, bus.rs2, h.rs1, h.rs2); end
        checks++; if (bus.immediateI !== h.imm || bus.funct3 !== h.f3 || bus.funct7 !== h.f7 || bus.rd_addr !== h.rd || bus.aluMode !== REGISTER) begin
            errors++; $display("FAIL reset_control: got imm=%h f3=%h f7=%h rd=%h mode=%0d want zeros/REGISTER", bus.immediateI, bus.funct3, bus.funct7, bus.rd_addr, bus.aluMode); end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_write_read();
        exp_t h;
        bus.out_ready = 1'b1;
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
        set_wr(1'b1, 5'd0, 32'h1234);
        set_in(1'b1, 5'd5, 5'd0, 5'd10, 32'h0000_0FFF, 3'd2, 7'd0, OP_IMM);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %0b want 1", bus.out_valid); end
        checks++; if (bus.rs1 !== h.rs1 || bus.rs1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_rs1: got %h want %h", bus.rs1, h.rs1); end
        checks++; if (bus.rs2 !== h.rs2 || bus.immediateI !== h.imm || bus.aluMode !== h.mode || bus.rd_addr !== h.rd) begin
            errors++; $display("FAIL wr_rd_fields: got rs2=%h imm=%h mode=%0d rd=%h want %h %h %0d %h", bus.rs2, bus.immediateI, bus.aluMode, bus.rd_addr, h.rs2, h.imm, h.mode, h.rd); end
        set_wr(1'b0, 5'd0, 32'd0);
        set_in(1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs1 !== h.rs1 || bus.rs1 !== 32'd0) begin errors++; $display("FAIL x0_read: got %h want %h", bus.rs1, h.rs1); end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t h;
        bus.out_ready = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        for (int i = 1; i <= 3; i++) begin
            set_wr(1'b1, 5'(i), 32'(i));
            tick();
        end
        set_wr(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 5'(i), 5'd0, 5'(i + 20), 32'(i * 16), 3'(i), 7'd0, REGISTER);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %0b want 1", i, bus.in_ready); end
            tick();
            h = (sb.size() != 0) ? sb[0] : last;
            checks++; if (bus.out_valid !== 1'b1 || bus.rs1 !== h.rs1 || bus.rs1 !== 32'(i)) begin
                errors++; $display("FAIL b2b_rs1[%0d]: got valid=%0b rs1=%h want valid=1 rs1=%h", i, bus.out_valid, bus.rs1, h.rs1); end
            checks++; if (bus.rd_addr !== h.rd || bus.funct3 !== h.f3) begin errors++; $display("FAIL b2b_ctrl[%0d]: got rd=%h f3=%h want %h %h", i, bus.rd_addr, bus.funct3, h.rd, h.f3); end
        end
    endtask

    task automatic test_backpressure();
        exp_t h;
        // Entry from previous test is consumed at this edge and replaced.
        bus.out_ready = 1'b1;
        set_in(1'b1, 5'd3, 5'd7, 5'd12, 32'h0000_0ABC, 3'd5, 7'h20, OP_IMM);
        tick();
        bus.out_ready = 1'b0;
        set_in(1'b1, 5'd1, 5'd2, 5'd13, 32'h0000_0111, 3'd1, 7'h00, REGISTER);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.out_valid !== 1'b1 || bus.immediateI !== h.imm || bus.rd_addr !== h.rd || bus.funct7 !== h.f7 || bus.aluMode !== h.mode) begin
            errors++; $display("FAIL bp_hold: got v=%0b imm=%h rd=%h f7=%h mode=%0d want 1 %h %h %h %0d", bus.out_valid, bus.immediateI, bus.rd_addr, bus.funct7, bus.aluMode, h.imm, h.rd, h.f7, h.mode); end
        set_wr(1'b1, 5'd7, 32'h55);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs2 !== h.rs2 || bus.rs2 !== 32'h55) begin errors++; $display("FAIL bp_refresh_rs2: got %h want %h", bus.rs2, h.rs2); end
        checks++; if (bus.rs1 !== h.rs1) begin errors++; $display("FAIL bp_rs1_kept: got %h want %h", bus.rs1, h.rs1); end
        set_wr(1'b1, 5'd3, 32'h77);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs1 !== h.rs1 || bus.rs1 !== 32'h77) begin errors++; $display("FAIL bp_refresh_rs1: got %h want %h", bus.rs1, h.rs1); end
        set_wr(1'b0, 5'd0, 32'd0);
        bus.out_ready = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL bp_consumed: got %0b want %0b", bus.out_valid, sb.size() != 0); end
    endtask

    task automatic test_hazard();
        exp_t        h;
        logic [31:0] want;
`ifdef OPERAND_FETCH_BYPASS_EN
        want = 32'hA5A5A5A5;
`else
        want = 32'h11;
`endif
        bus.out_ready = 1'b1;
        set_wr(1'b1, 5'd9, 32'h11);
        tick();
        set_wr(1'b1, 5'd9, 32'hA5A5A5A5);
        set_in(1'b1, 5'd9, 5'd9, 5'd4, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs1 !== h.rs1 || bus.rs1 !== want) begin errors++; $display("FAIL hazard_rs1: got %h want %h", bus.rs1, want); end
        checks++; if (bus.rs2 !== h.rs2) begin errors++; $display("FAIL hazard_rs2: got %h want %h", bus.rs2, h.rs2); end
        set_wr(1'b0, 5'd0, 32'd0);
        set_in(1'b1, 5'd9, 5'd0, 5'd4, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs1 !== h.rs1 || bus.rs1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL hazard_after: got %h want A5A5A5A5", bus.rs1); end
    endtask

    task automatic test_drain();
        exp_t h;
        bus.out_ready = 1'b1;
        set_in(1'b1, 5'd5, 5'd9, 5'd31, 32'hFFFF_F800, 3'd7, 7'h7F, OP_IMM);
        tick();
        set_in(1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 3'd1, 7'd1, REGISTER);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.immediateI !== h.imm || bus.funct3 !== h.f3 || bus.funct7 !== h.f7 || bus.aluMode !== h.mode || bus.rd_addr !== h.rd) begin
            errors++; $display("FAIL drain_retain: got imm=%h f3=%h f7=%h mode=%0d rd=%h want %h %h %h %0d %h", bus.immediateI, bus.funct3, bus.funct7, bus.aluMode, bus.rd_addr, h.imm, h.f3, h.f7, h.mode, h.rd); end
    endtask

    task automatic test_reset_mid();
        exp_t h;
        bus.out_ready = 1'b0;
        set_in(1'b1, 5'd5, 5'd9, 5'd2, 32'h42, 3'd3, 7'd0, OP_IMM);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_full: got %0b want 1", bus.out_valid); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.rs1 !== 32'd0 || bus.aluMode !== REGISTER) begin
            errors++; $display("FAIL rst_mid_async: got v=%0b rs1=%h mode=%0d want 0 0 REGISTER", bus.out_valid, bus.rs1, bus.aluMode); end
        @(negedge clock);
        reset = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_release: got rdy=%0b v=%0b want 1 0", bus.in_ready, bus.out_valid); end
        set_in(1'b1, 5'd5, 5'd9, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs1 !== h.rs1 || bus.rs2 !== h.rs2 || bus.rs1 !== 32'd0 || bus.rs2 !== 32'd0) begin
            errors++; $display("FAIL rst_regs_cleared: got %h/%h want 0/0", bus.rs1, bus.rs2); end
        set_in(1'b1, 5'd1, 5'd3, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
        h = (sb.size() != 0) ? sb[0] : last;
        checks++; if (bus.rs1 !== h.rs1 || bus.rs2 !== h.rs2 || bus.rs1 !== 32'd0) begin
            errors++; $display("FAIL rst_regs_cleared2: got %h/%h want %h/%h", bus.rs1, bus.rs2, h.rs1, h.rs2); end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        tick();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 7'd0, REGISTER);
        set_wr(1'b0, 5'd0, 32'd0);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_hazard();
        test_drain();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
